// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: round-robin arbiter sharing one resource among four requesters.
// One requester is granted at a time. The grant is held until that requester
// drops its request or, when MAX_HOLD is nonzero, until MAX_HOLD cycles have
// elapsed. At least one idle cycle always separates consecutive grants.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [3:0] request per requester, held high while using the resource
//   gnt      out  [3:0] one-hot grant, 4'b0000 when idle
//   gnt_idx  out  [1:0] index of the current or last winner
//   busy     out  high while a grant is active
//   timeout  out  one-cycle pulse when a grant is revoked by MAX_HOLD
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no grant; arbitrate among req on the next edge
// GRANT  | gnt_idx owns the resource; hold_cnt counts cycles held
module rr_arbiter_4 #(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;
   localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [1:0]        gnt_idx_q, gnt_idx_d;
   logic [1:0]        last_q, last_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              timeout_q, timeout_d;
   logic [1:0]        winner;

   function automatic logic [3:0] dec_2to4(input logic [1:0] idx);
      dec_2to4 = 4'b0001 << idx;
   endfunction

   // Search order last+1, last+2, last+3, last. Walking the offsets from the
   // farthest to the nearest lets the nearest set bit overwrite the result.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
      logic [1:0] cand;
      rr_pick = last;
      for (int i = 4; i >= 1; i--) begin
         cand = last + 2'(i);
         if (r[cand]) rr_pick = cand;
      end
   endfunction

   always_comb begin
      state_d    = state_q;
      gnt_idx_d  = gnt_idx_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;
      winner     = rr_pick(req, last_q);
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               gnt_idx_d  = winner;
               last_d     = winner;
               hold_cnt_d = '0;
               state_d    = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // Release is checked first so it masks a coincident timeout.
            if (!req[gnt_idx_q]) begin
               state_d = ST_IDLE;
            end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else if (hold_cnt_q != HOLD_SAT) begin
               hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gnt_idx_q  <= 2'd0;
         last_q     <= 2'd3;
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_idx_q  <= gnt_idx_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign busy    = (state_q == ST_GRANT);
   assign gnt     = busy ? dec_2to4(gnt_idx_q) : 4'b0000;
   assign gnt_idx = gnt_idx_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: vector tables pushed through a scoreboard queue,
// plus hand-written sequences for async reset and the unlimited-hold case.
module tb_rr_arbiter_4;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic       busy;
      logic       to;
      logic [1:0] idx;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req, req_h;
   logic [3:0] gnt, gnt_h;
   logic [1:0] gnt_idx, gnt_idx_h;
   logic       busy, busy_h, timeout, timeout_h;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t sb_q[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   rr_arbiter_4 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
      .gnt_idx(gnt_idx), .busy(busy), .timeout(timeout)
   );

   rr_arbiter_4 #(.MAX_HOLD(0), .HOLD_W(8)) dut_h (
      .clk(clk), .rst_n(rst_n), .req(req_h), .gnt(gnt_h),
      .gnt_idx(gnt_idx_h), .busy(busy_h), .timeout(timeout_h)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g, input logic b,
                               input logic t, input logic [1:0] i);
      vec_t v;
      v.req = r; v.gnt = g; v.busy = b; v.to = t; v.idx = i;
      return v;
   endfunction

   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      @(negedge clk);
      req = v.req;
      sb_q.push_back(v);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk({tag, " gnt"},     32'(gnt),     32'(e.gnt));
      chk({tag, " busy"},    32'(busy),    32'(e.busy));
      chk({tag, " timeout"}, 32'(timeout), 32'(e.to));
      chk({tag, " gnt_idx"}, 32'(gnt_idx), 32'(e.idx));
   endtask

   task automatic run_table(input string tag);
      foreach (tbl[k]) apply(tbl[k], $sformatf("%s[%0d]", tag, k));
      tbl.delete();
   endtask

   task automatic do_reset();
      req   = 4'b0000;
      req_h = 4'b0000;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset gnt",     32'(gnt),     32'h0);
      chk("reset busy",    32'(busy),    32'h0);
      chk("reset timeout", 32'(timeout), 32'h0);
      chk("reset gnt_idx", 32'(gnt_idx), 32'h0);
   endtask

   initial begin
      req   = 4'b0000;
      req_h = 4'b0000;
      rst_n = 1'b0;

      // 1: all requesting, four-cycle grants rotating 0,1,2,3,0 with a
      //    timeout idle cycle after each.
      do_reset();
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < 4; c++)
            tbl.push_back(mk(4'b1111, 4'b0001 << (g % 4), 1'b1, 1'b0, 2'(g % 4)));
         tbl.push_back(mk(4'b1111, 4'b0000, 1'b0, 1'b1, 2'(g % 4)));
      end
      run_table("t1");

      // 2: short request on idx 2, released before the hold limit.
      do_reset();
      tbl.push_back(mk(4'b0100, 4'b0100, 1'b1, 1'b0, 2'd2));
      tbl.push_back(mk(4'b0100, 4'b0100, 1'b1, 1'b0, 2'd2));
      tbl.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2));
      tbl.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2));
      run_table("t2");

      // 4: last=2 from test 2; req 0101 picks 0 first, then 2.
      tbl.push_back(mk(4'b0101, 4'b0001, 1'b1, 1'b0, 2'd0));
      tbl.push_back(mk(4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0));
      tbl.push_back(mk(4'b0100, 4'b0100, 1'b1, 1'b0, 2'd2));
      tbl.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2));
      run_table("t4");

      // 3: release on the same edge the hold limit would fire.
      do_reset();
      for (int c = 0; c < 4; c++)
         tbl.push_back(mk(4'b0010, 4'b0010, 1'b1, 1'b0, 2'd1));
      tbl.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1));
      tbl.push_back(mk(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1));
      run_table("t3");

      // 5: asynchronous reset between edges while granted.
      do_reset();
      apply(mk(4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0), "t5 pre0");
      apply(mk(4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0), "t5 pre1");
      #2;
      req   = 4'b0000;
      rst_n = 1'b0;
      #1;
      chk("t5 async gnt",     32'(gnt),     32'h0);
      chk("t5 async busy",    32'(busy),    32'h0);
      chk("t5 async gnt_idx", 32'(gnt_idx), 32'h0);
      chk("t5 async timeout", 32'(timeout), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(mk(4'b1000, 4'b1000, 1'b1, 1'b0, 2'd3), "t5 post");

      // 6: unlimited hold, grant never revoked, counter saturates.
      do_reset();
      @(negedge clk);
      req_h = 4'b0010;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("t6 gnt c%0d", c),     32'(gnt_h),     32'h2);
         chk($sformatf("t6 timeout c%0d", c), 32'(timeout_h), 32'h0);
      end
      chk("t6 hold_cnt sat", 32'(dut_h.hold_cnt_q), 32'd255);
      req_h = 4'b0000;
      @(posedge clk);
      #1;
      chk("t6 release busy", 32'(busy_h), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
